loopback_rx_checker: RTL and testbench
======================================

Name: loopback_rx_checker

Overview:
- Monitors the 10GbE loopback receive stream in the user clock domain.
- Checks every frame for the expected length and word-index payload pattern.
- Counts good frames and bad frames.
- Its 32-bit rx_cnt output drives user_data_in of the loopback_rx_cnt software register, which PPC software reads over OPB; rx_err_cnt feeds a sibling register.

Parameters:
- DATA_WIDTH, 64: width of rx_data.
- FRAME_LEN, 128: expected words per frame; legal range 1..65535.
- CNT_WIDTH, 32: width of the frame counters; matches the register width.
- LEN_WIDTH, 16: width of the internal word-index counter.

Ports:
- user_clk, in, 1: the single clock for the block.
- user_rst, in, 1: synchronous, active-high reset.
- cnt_rst, in, 1: synchronous, active-high counter clear, driven by a PPC-written register bit.
- rx_valid, in, 1: rx_data beat valid.
- rx_data, in, DATA_WIDTH: received word; bits [LEN_WIDTH-1:0] carry the word index.
- rx_eof, in, 1: last beat of a frame; qualified by rx_valid.
- rx_overrun, in, 1: receive-buffer overrun flag from the core; qualified by rx_valid.
- rx_cnt, out, CNT_WIDTH: good-frame count.
- rx_err_cnt, out, CNT_WIDTH: bad-frame count.
- last_err, out, 1: 1 when the most recently completed frame was bad.

Behaviour:
- Clock and reset: one clock, user_clk. Reset is synchronous and active-high on user_rst.
- Reset values: rx_cnt=0, rx_err_cnt=0, last_err=0, state=IDLE, word index=0, bad flag=0.
- Beat qualification: only cycles with rx_valid=1 are beats. rx_eof and rx_overrun are ignored when rx_valid=0.
- FSM states: IDLE, FRAME, BAD.
- IDLE:
  - Beat with rx_eof=1: single-word frame; complete it this cycle.
  - Beat with rx_eof=0: go to FRAME, or to BAD if that beat is bad; word index becomes 1.
- FRAME:
  - Each beat checks rx_data[LEN_WIDTH-1:0] == word index.
  - Mismatch, rx_overrun=1, or word index >= FRAME_LEN: go to BAD.
  - Word index increments per beat and saturates at 2^LEN_WIDTH-1.
- BAD: absorbs beats without checking until rx_eof.
- Frame completion (eof beat):
  - Good iff the frame never entered BAD, the eof beat itself passes the checks, and total beats == FRAME_LEN.
  - Length check: total beats = word index + 1 on the eof beat.
  - Next state is always IDLE; word index returns to 0.
- Counter update:
  - One cycle after the eof beat, rx_cnt or rx_err_cnt increments by 1 and last_err updates.
  - Counters wrap from 2^CNT_WIDTH-1 to 0; there is no saturation.
- cnt_rst:
  - Clears rx_cnt, rx_err_cnt and last_err the next cycle. The FSM is unaffected.
  - If a frame completes in the same cycle as cnt_rst, the clear wins and that frame is not counted.
- user_rst mid-frame: FSM returns to IDLE. The following beats are treated as a new frame, so the remainder of the interrupted frame is counted as bad, since its index does not start at 0.
- Back-to-back frames: an eof beat followed on the next cycle by a first beat is legal. Throughput is one beat per cycle with no stall and no backpressure.
- Outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Package loopback_pkg holds:
  - state enum (IDLE, FRAME, BAD);
  - default constants LOOPBACK_FRAME_LEN=128 and LOOPBACK_CNT_WIDTH=32, shared with the transmit pattern generator.
- One sub-module, loopback_wrap_cnt: a CNT_WIDTH counter with synchronous clear and increment enable, clear taking priority. It is instantiated twice, once for rx_cnt and once for rx_err_cnt.

Test Plan:
- Reset: assert user_rst for 2 cycles during a frame, then release. rx_cnt=0, rx_err_cnt=0, last_err=0; the partial frame that follows increments rx_err_cnt to 1.
- Good frames: FRAME_LEN=4, send 3 back-to-back frames with indices 0,1,2,3 and eof on index 3. rx_cnt steps 1,2,3, each 1 cycle after its eof; rx_err_cnt=0.
- Data error: index sequence 0,1,7,3. rx_err_cnt=1, last_err=1, rx_cnt unchanged. The next good frame gives rx_cnt+1 and last_err=0.
- Length errors:
  - 3-beat frame → rx_err_cnt+1.
  - 6-beat frame → rx_err_cnt+1.
  - Single-beat frame with FRAME_LEN=4 → rx_err_cnt+1.
  - Single-beat frame with FRAME_LEN=1 and index 0 → rx_cnt+1.
- Overrun and idle gaps: rx_overrun=1 on beat 2 → rx_err_cnt+1. rx_overrun=1 with rx_valid=0 between frames → no effect.
- Clear and wrap:
  - Preload rx_cnt to 0xFFFFFFFF, complete one good frame → rx_cnt=0.
  - cnt_rst in the same cycle as an eof beat → both counters 0 and that frame not counted.

Source files
------------

// File: rtl/loopback_pkg.sv
// rtl/loopback_pkg.sv - shared types and defaults for the 10GbE loopback pattern path
package loopback_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        BAD   = 2'd2
    } state_t;

    // Shared with the transmit pattern generator so both ends agree on framing.
    localparam int LOOPBACK_FRAME_LEN = 128;
    localparam int LOOPBACK_CNT_WIDTH = 32;

endpackage

// File: rtl/loopback_wrap_cnt.sv
// rtl/loopback_wrap_cnt.sv - free-running wrapping counter with synchronous clear
module loopback_wrap_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    // Clear beats increment; the counter wraps to zero with no saturation.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/loopback_rx_checker.sv
// rtl/loopback_rx_checker.sv - checks loopback frames for length and word-index pattern, counts good/bad
module loopback_rx_checker
    import loopback_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int FRAME_LEN  = LOOPBACK_FRAME_LEN,
    parameter int CNT_WIDTH  = LOOPBACK_CNT_WIDTH,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  user_clk,
    input  logic                  user_rst,
    input  logic                  cnt_rst,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_eof,
    input  logic                  rx_overrun,
    output logic [CNT_WIDTH-1:0]  rx_cnt,
    output logic [CNT_WIDTH-1:0]  rx_err_cnt,
    output logic                  last_err
);

    localparam logic [LEN_WIDTH:0]   L_FRAME_LEN = (LEN_WIDTH+1)'(FRAME_LEN);
    localparam logic [LEN_WIDTH-1:0] L_IDX_MAX   = '1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [LEN_WIDTH-1:0] r_idx;
    logic [LEN_WIDTH-1:0] w_idx_nxt;
    logic                 r_last_err;
    logic                 w_beat_bad;
    logic                 w_len_ok;
    logic                 w_good;
    logic                 w_done_good;
    logic                 w_done_bad;
    logic                 w_cnt_clr;
    logic                 w_unused;

    assign w_unused = ^rx_data[DATA_WIDTH-1:LEN_WIDTH];

    // In IDLE the index is 0, so the same per-beat check covers the first beat.
    assign w_beat_bad = (rx_data[LEN_WIDTH-1:0] != r_idx) || rx_overrun
                        || ({1'b0, r_idx} >= L_FRAME_LEN);
    // Widened by one bit so a saturated index can never alias a legal length.
    assign w_len_ok   = ({1'b0, r_idx} + (LEN_WIDTH+1)'(1)) == L_FRAME_LEN;
    assign w_good     = (r_state != BAD) && !w_beat_bad && w_len_ok;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_done_good = 1'b0;
        w_done_bad  = 1'b0;
        if (rx_valid) begin
            w_idx_nxt = (r_idx == L_IDX_MAX) ? r_idx : r_idx + LEN_WIDTH'(1);
            if (rx_eof) begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
                w_done_good = w_good;
                w_done_bad  = !w_good;
            end else begin
                case (r_state)
                    IDLE, FRAME: w_state_nxt = w_beat_bad ? BAD : FRAME;
                    BAD:         w_state_nxt = BAD;
                    default:     w_state_nxt = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // A frame finishing alongside cnt_rst is dropped: clear has priority below.
    assign w_cnt_clr = user_rst || cnt_rst;

    always_ff @(posedge user_clk) begin
        if (w_cnt_clr) begin
            r_last_err <= 1'b0;
        end else if (w_done_good || w_done_bad) begin
            r_last_err <= w_done_bad;
        end
    end

    loopback_wrap_cnt #(
        .WIDTH (CNT_WIDTH)
    ) u_good_cnt (
        .i_clk (user_clk),
        .i_clr (w_cnt_clr),
        .i_inc (w_done_good),
        .o_cnt (rx_cnt)
    );

    loopback_wrap_cnt #(
        .WIDTH (CNT_WIDTH)
    ) u_bad_cnt (
        .i_clk (user_clk),
        .i_clr (w_cnt_clr),
        .i_inc (w_done_bad),
        .o_cnt (rx_err_cnt)
    );

    assign last_err = r_last_err;

endmodule

// File: tb/tb_loopback_rx_checker.sv
// tb/tb_loopback_rx_checker.sv - directed self-checking bench for loopback_rx_checker
module tb_loopback_rx_checker;

    logic        clk;
    logic        rst;

    logic        a_cnt_rst;
    logic        a_valid;
    logic [63:0] a_data;
    logic        a_eof;
    logic        a_ovr;
    logic [31:0] a_cnt;
    logic [31:0] a_err;
    logic        a_last;

    logic        b_cnt_rst;
    logic        b_valid;
    logic [63:0] b_data;
    logic        b_eof;
    logic        b_ovr;
    logic [3:0]  b_cnt;
    logic [3:0]  b_err;
    logic        b_last;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    loopback_rx_checker #(
        .DATA_WIDTH (64),
        .FRAME_LEN  (4),
        .CNT_WIDTH  (32),
        .LEN_WIDTH  (16)
    ) dut_a (
        .user_clk   (clk),
        .user_rst   (rst),
        .cnt_rst    (a_cnt_rst),
        .rx_valid   (a_valid),
        .rx_data    (a_data),
        .rx_eof     (a_eof),
        .rx_overrun (a_ovr),
        .rx_cnt     (a_cnt),
        .rx_err_cnt (a_err),
        .last_err   (a_last)
    );

    loopback_rx_checker #(
        .DATA_WIDTH (64),
        .FRAME_LEN  (1),
        .CNT_WIDTH  (4),
        .LEN_WIDTH  (16)
    ) dut_b (
        .user_clk   (clk),
        .user_rst   (rst),
        .cnt_rst    (b_cnt_rst),
        .rx_valid   (b_valid),
        .rx_data    (b_data),
        .rx_eof     (b_eof),
        .rx_overrun (b_ovr),
        .rx_cnt     (b_cnt),
        .rx_err_cnt (b_err),
        .last_err   (b_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input int idx, input bit eof, input bit ovr);
        a_valid = 1'b1;
        a_data  = {48'h5A5A_C3C3_0F0F, idx[15:0]};
        a_eof   = eof;
        a_ovr   = ovr;
        tick();
        a_valid = 1'b0;
        a_eof   = 1'b0;
        a_ovr   = 1'b0;
    endtask

    task automatic send_b(input int idx, input bit eof);
        b_valid = 1'b1;
        b_data  = {48'hFFFF_0000_1234, idx[15:0]};
        b_eof   = eof;
        tick();
        b_valid = 1'b0;
        b_eof   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        assert_cnt++; if (a_cnt !== 32'd0) begin fail_cnt++; $display("FAIL reset_cnt: got %0d expected 0", a_cnt); end
        assert_cnt++; if (a_err !== 32'd0) begin fail_cnt++; $display("FAIL reset_err: got %0d expected 0", a_err); end
        assert_cnt++; if (a_last !== 1'b0) begin fail_cnt++; $display("FAIL reset_last: got %0b expected 0", a_last); end
        assert_cnt++; if (b_cnt !== 4'd0) begin fail_cnt++; $display("FAIL reset_b_cnt: got %0d expected 0", b_cnt); end
        send_a(0, 0, 0);
        send_a(1, 0, 0);
        rst = 1'b1;
        send_a(2, 0, 0);
        send_a(3, 0, 0);
        rst = 1'b0;
        assert_cnt++; if (a_err !== 32'd0) begin fail_cnt++; $display("FAIL reset_mid_err: got %0d expected 0", a_err); end
        send_a(4, 0, 0);
        send_a(5, 1, 0);
        assert_cnt++; if (a_err !== 32'd1) begin fail_cnt++; $display("FAIL reset_partial_err: got %0d expected 1", a_err); end
        assert_cnt++; if (a_cnt !== 32'd0) begin fail_cnt++; $display("FAIL reset_partial_cnt: got %0d expected 0", a_cnt); end
        assert_cnt++; if (a_last !== 1'b1) begin fail_cnt++; $display("FAIL reset_partial_last: got %0b expected 1", a_last); end
        a_cnt_rst = 1'b1;
        tick();
        a_cnt_rst = 1'b0;
        assert_cnt++; if (a_err !== 32'd0) begin fail_cnt++; $display("FAIL cnt_rst_err: got %0d expected 0", a_err); end
        assert_cnt++; if (a_last !== 1'b0) begin fail_cnt++; $display("FAIL cnt_rst_last: got %0b expected 0", a_last); end
    endtask

    task automatic test_back_to_back();
        for (int f = 1; f <= 3; f++) begin
            for (int i = 0; i < 4; i++) begin
                send_a(i, i == 3, 0);
                if (i == 2) begin
                    assert_cnt++; if (a_cnt !== 32'(f - 1)) begin fail_cnt++; $display("FAIL b2b_pre_eof f%0d: got %0d expected %0d", f, a_cnt, f - 1); end
                end
            end
            assert_cnt++; if (a_cnt !== 32'(f)) begin fail_cnt++; $display("FAIL b2b_cnt f%0d: got %0d expected %0d", f, a_cnt, f); end
        end
        assert_cnt++; if (a_err !== 32'd0) begin fail_cnt++; $display("FAIL b2b_err: got %0d expected 0", a_err); end
        assert_cnt++; if (a_last !== 1'b0) begin fail_cnt++; $display("FAIL b2b_last: got %0b expected 0", a_last); end
    endtask

    task automatic test_data_error();
        send_a(0, 0, 0);
        send_a(1, 0, 0);
        send_a(7, 0, 0);
        send_a(3, 1, 0);
        assert_cnt++; if (a_err !== 32'd1) begin fail_cnt++; $display("FAIL data_err_err: got %0d expected 1", a_err); end
        assert_cnt++; if (a_last !== 1'b1) begin fail_cnt++; $display("FAIL data_err_last: got %0b expected 1", a_last); end
        assert_cnt++; if (a_cnt !== 32'd3) begin fail_cnt++; $display("FAIL data_err_cnt: got %0d expected 3", a_cnt); end
        for (int i = 0; i < 4; i++) send_a(i, i == 3, 0);
        assert_cnt++; if (a_cnt !== 32'd4) begin fail_cnt++; $display("FAIL data_recover_cnt: got %0d expected 4", a_cnt); end
        assert_cnt++; if (a_last !== 1'b0) begin fail_cnt++; $display("FAIL data_recover_last: got %0b expected 0", a_last); end
    endtask

    task automatic test_length_errors();
        for (int i = 0; i < 3; i++) send_a(i, i == 2, 0);
        assert_cnt++; if (a_err !== 32'd2) begin fail_cnt++; $display("FAIL len_short: got %0d expected 2", a_err); end
        for (int i = 0; i < 6; i++) send_a(i, i == 5, 0);
        assert_cnt++; if (a_err !== 32'd3) begin fail_cnt++; $display("FAIL len_long: got %0d expected 3", a_err); end
        send_a(0, 1, 0);
        assert_cnt++; if (a_err !== 32'd4) begin fail_cnt++; $display("FAIL len_single: got %0d expected 4", a_err); end
        assert_cnt++; if (a_cnt !== 32'd4) begin fail_cnt++; $display("FAIL len_cnt_hold: got %0d expected 4", a_cnt); end
        send_b(0, 1);
        assert_cnt++; if (b_cnt !== 4'd1) begin fail_cnt++; $display("FAIL len1_good: got %0d expected 1", b_cnt); end
        send_b(1, 1);
        assert_cnt++; if (b_err !== 4'd1) begin fail_cnt++; $display("FAIL len1_bad_idx: got %0d expected 1", b_err); end
    endtask

    task automatic test_overrun_gap();
        send_a(0, 0, 0);
        send_a(1, 0, 1);
        send_a(2, 0, 0);
        send_a(3, 1, 0);
        assert_cnt++; if (a_err !== 32'd5) begin fail_cnt++; $display("FAIL overrun_err: got %0d expected 5", a_err); end
        a_ovr = 1'b1;
        a_eof = 1'b1;
        a_data = 64'd3;
        tick();
        tick();
        tick();
        a_ovr = 1'b0;
        a_eof = 1'b0;
        assert_cnt++; if (a_err !== 32'd5) begin fail_cnt++; $display("FAIL gap_err: got %0d expected 5", a_err); end
        assert_cnt++; if (a_last !== 1'b1) begin fail_cnt++; $display("FAIL gap_last: got %0b expected 1", a_last); end
        for (int i = 0; i < 4; i++) send_a(i, i == 3, 0);
        assert_cnt++; if (a_cnt !== 32'd5) begin fail_cnt++; $display("FAIL gap_good_cnt: got %0d expected 5", a_cnt); end
        assert_cnt++; if (a_err !== 32'd5) begin fail_cnt++; $display("FAIL gap_good_err: got %0d expected 5", a_err); end
    endtask

    task automatic test_clear_same_cycle();
        send_a(0, 0, 0);
        send_a(1, 0, 0);
        send_a(2, 0, 0);
        a_cnt_rst = 1'b1;
        send_a(3, 1, 0);
        a_cnt_rst = 1'b0;
        assert_cnt++; if (a_cnt !== 32'd0) begin fail_cnt++; $display("FAIL clr_eof_cnt: got %0d expected 0", a_cnt); end
        assert_cnt++; if (a_err !== 32'd0) begin fail_cnt++; $display("FAIL clr_eof_err: got %0d expected 0", a_err); end
        tick();
        assert_cnt++; if (a_cnt !== 32'd0) begin fail_cnt++; $display("FAIL clr_eof_late: got %0d expected 0", a_cnt); end
        for (int i = 0; i < 4; i++) send_a(i, i == 3, 0);
        assert_cnt++; if (a_cnt !== 32'd1) begin fail_cnt++; $display("FAIL clr_fsm_ok: got %0d expected 1", a_cnt); end
    endtask

    task automatic test_wrap();
        b_cnt_rst = 1'b1;
        tick();
        b_cnt_rst = 1'b0;
        for (int i = 1; i <= 15; i++) send_b(0, 1);
        assert_cnt++; if (b_cnt !== 4'hF) begin fail_cnt++; $display("FAIL wrap_max: got %0d expected 15", b_cnt); end
        send_b(0, 1);
        assert_cnt++; if (b_cnt !== 4'h0) begin fail_cnt++; $display("FAIL wrap_zero: got %0d expected 0", b_cnt); end
        assert_cnt++; if (b_err !== 4'h0) begin fail_cnt++; $display("FAIL wrap_err: got %0d expected 0", b_err); end
        assert_cnt++; if (b_last !== 1'b0) begin fail_cnt++; $display("FAIL wrap_last: got %0b expected 0", b_last); end
    endtask

    initial begin
        rst       = 1'b1;
        a_cnt_rst = 1'b0;
        a_valid   = 1'b0;
        a_data    = '0;
        a_eof     = 1'b0;
        a_ovr     = 1'b0;
        b_cnt_rst = 1'b0;
        b_valid   = 1'b0;
        b_data    = '0;
        b_eof     = 1'b0;
        b_ovr     = 1'b0;
        test_reset();
        test_back_to_back();
        test_data_error();
        test_length_errors();
        test_overrun_gap();
        test_clear_same_cycle();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
